// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    // Default geometry for the DSP/NCO/correlator sample chain
    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 16;

    // Ceiling log2, usable in parameter expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one clocked write port, one asynchronous read port.
// Kept separate so it can later be swapped for a block RAM with registered read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Storage is intentionally not reset
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: capture data on the rising edge when enabled
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: combinational show-ahead
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with fill level, programmable almost flags and
// sticky overflow/underflow. Uses all DEPTH entries; read+write allowed when full.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = FIFO_WIDTH,
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_empty,
    output logic             o_almost_full,
    output logic [AW:0]      o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [AW:0] L_ONE = (AW + 1)'(1);
    localparam logic [AW:0] L_AF  = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] L_AE  = (AW + 1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_overflow;
    logic        r_underflow;

    logic [AW:0] w_wr_ptr_next;
    logic [AW:0] w_rd_ptr_next;
    logic [AW:0] w_count_next;
    logic        w_overflow_next;
    logic        w_underflow_next;

    logic        w_empty;
    logic        w_full;
    logic        w_rd_acc;
    logic        w_wr_acc;
    logic        w_mem_we;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // No same-cycle pass-through: a read needs data already stored.
    // A read accepted while full frees the slot the write lands in.
    assign w_rd_acc = i_rd && !w_empty;
    assign w_wr_acc = i_wr && (!w_full || w_rd_acc);

    // A flush discards the accesses of its own cycle
    assign w_mem_we = w_wr_acc && !i_clr;

    // Next-state for pointers, fill level and sticky error flags
    always_comb begin
        w_wr_ptr_next    = r_wr_ptr;
        w_rd_ptr_next    = r_rd_ptr;
        w_count_next     = r_count;
        w_overflow_next  = r_overflow;
        w_underflow_next = r_underflow;

        if (i_clr) begin
            w_wr_ptr_next    = '0;
            w_rd_ptr_next    = '0;
            w_count_next     = '0;
            w_overflow_next  = 1'b0;
            w_underflow_next = 1'b0;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_next = r_wr_ptr + L_ONE;
            end
            if (w_rd_acc) begin
                w_rd_ptr_next = r_rd_ptr + L_ONE;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_next = r_count + L_ONE;
                2'b01:   w_count_next = r_count - L_ONE;
                default: w_count_next = r_count;
            endcase

            if (i_wr && !w_wr_acc) begin
                w_overflow_next = 1'b1;
            end
            if (i_rd && !w_rd_acc) begin
                w_underflow_next = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (i_din),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (o_dout)
    );

    // Status outputs follow the registered state directly
    always_comb begin
        o_empty        = w_empty;
        o_full         = w_full;
        o_count        = r_count;
        o_almost_empty = (r_count <= L_AE);
        o_almost_full  = (r_count >= L_AF);
        o_overflow     = r_overflow;
        o_underflow    = r_underflow;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (WIDTH=8, DEPTH=16): table-driven vectors
// plus hand-written multi-cycle sequences.
module tb_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] pre_dout;

    fifo_param #(
        .WIDTH    (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_clr          (clr),
        .i_wr           (wr),
        .i_din          (din),
        .i_rd           (rd),
        .o_dout         (dout),
        .o_empty        (empty),
        .o_full         (full),
        .o_almost_empty (almost_empty),
        .o_almost_full  (almost_full),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       chk_dout;
        logic [7:0] dout;
        logic [4:0] count;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic w, input logic r, input logic [7:0] d,
                                input logic cd, input logic [7:0] ed, input logic [4:0] cnt,
                                input logic e, input logic f, input logic ae, input logic af,
                                input logic ov, input logic ud);
        vec_t v;
        v.clr = c; v.wr = w; v.rd = r; v.din = d;
        v.chk_dout = cd; v.dout = ed; v.count = cnt;
        v.empty = e; v.full = f; v.ae = ae; v.af = af; v.ovf = ov; v.udf = ud;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, snapshot show-ahead dout, check #1 after posedge
    task automatic cyc(input logic c, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        clr = c; wr = w; rd = r; din = d;
        #1 pre_dout = dout;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic [4:0] cnt, input logic e,
                              input logic f, input logic ae, input logic af,
                              input logic ov, input logic ud);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(ud));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] c;
        logic [7:0] d;

        // Fill to full with 0x00..0x0F; dout stays at the oldest word
        for (int i = 0; i < 16; i++) begin
            c = 5'(i + 1);
            vecs.push_back(mk(0, 1, 0, 8'(i), 1, 8'h00, c, 0, (i == 15), (c <= 2), (c >= 14),
                              0, 0));
        end
        // Write while full without read: rejected, sticky overflow
        vecs.push_back(mk(0, 1, 0, 8'hAA, 1, 8'h00, 5'd16, 0, 1, 0, 1, 1, 0));
        // Drain: dout walks 0x01..0x0F, never shows 0xAA
        for (int i = 0; i < 16; i++) begin
            c = 5'(15 - i);
            vecs.push_back(mk(0, 0, 1, 8'h00, (i < 15), 8'(i + 1), c, (i == 15), 0, (c <= 2),
                              (c >= 14), 1, 0));
        end
        // Read while empty: rejected, underflow, count stays 0
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 5'd0, 1, 0, 1, 0, 1, 1));
        // clr with a read pending: flags cleared, no new underflow
        vecs.push_back(mk(1, 0, 1, 8'h00, 0, 8'h00, 5'd0, 1, 0, 1, 0, 0, 0));

        // Reset state, checked while reset is held
        rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
        #12;
        chk_status("reset", 5'd0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            cyc(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk_status(tag, vecs[i].count, vecs[i].empty, vecs[i].full, vecs[i].ae, vecs[i].af,
                       vecs[i].ovf, vecs[i].udf);
            if (vecs[i].chk_dout) begin
                chk({tag, ".dout"}, 32'(dout), 32'(vecs[i].dout));
            end
        end

        // Full FIFO with simultaneous read+write: count holds, 0x55 comes out last
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'(i));
        chk("full_rw.pre_full", 32'(full), 32'd1);
        cyc(0, 1, 1, 8'h55);
        chk("full_rw.pre_dout", 32'(pre_dout), 32'h00);
        chk_status("full_rw", 5'd16, 0, 1, 0, 1, 0, 0);
        chk("full_rw.dout", 32'(dout), 32'h01);
        for (int k = 0; k < 16; k++) begin
            d = (k < 15) ? 8'(k + 1) : 8'h55;
            cyc(0, 0, 1, 8'h00);
            chk($sformatf("full_rw.read%0d", k), 32'(pre_dout), 32'(d));
        end
        chk_status("full_rw.end", 5'd0, 1, 0, 1, 0, 0, 0);

        // Streaming read+write from count=3 across several pointer wraps
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'(8'h80 + i));
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1, 1, 8'(8'h83 + k));
            chk($sformatf("stream%0d.dout", k), 32'(pre_dout), 32'(8'(8'h80 + k)));
            chk($sformatf("stream%0d.count", k), 32'(count), 32'd3);
        end
        chk("stream.tail", 32'(dout), 32'hA8);
        chk("stream.ovf_udf", 32'({overflow, underflow}), 32'd0);
        cyc(1, 0, 0, 8'h00);

        // Empty FIFO with read+write: write lands, read rejected
        cyc(0, 1, 1, 8'h77);
        chk_status("empty_rw", 5'd1, 0, 0, 1, 0, 0, 1);
        chk("empty_rw.dout", 32'(dout), 32'h77);

        // Build up to count=9, then pull reset low mid-cycle during the burst
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'(8'h60 + i));
        chk("burst.count", 32'(count), 32'd9);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; clr = 1'b0; din = 8'h70;
        #2 rst_n = 1'b0;
        #1;
        chk_status("midreset", 5'd0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; wr = 1'b0;
        cyc(0, 0, 0, 8'h00);
        chk_status("postreset", 5'd0, 1, 0, 1, 0, 0, 0);

        // clr together with a write: nothing stored
        cyc(0, 1, 0, 8'h11);
        cyc(0, 1, 0, 8'h22);
        cyc(1, 1, 0, 8'h99);
        chk_status("clr_wr", 5'd0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 8'h00);
        chk_status("clr_wr.idle", 5'd0, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 8'h42);
        chk("clr_wr.next_dout", 32'(dout), 32'h42);
        chk("clr_wr.next_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: the next-generation buffer for the DSP/NCO/correlator datapath. It is generic in data width and depth and uses all DEPTH entries. It adds a fill level, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and simultaneous read+write while full. It sits between sample producers (NCO/correlator) and slower consumers (UART/debug readout) in the same clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of storage entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- AW (localparam), clog2(DEPTH), address width; pointers are AW+1 bits
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset; deassertion is synchronised outside this block
- clr  in  1  synchronous flush: pointers and count to 0, error flags cleared
- wr  in  1  write request
- din  in  WIDTH  write data
- rd  in  1  read request (acknowledge of current dout)
- dout  out  WIDTH  show-ahead data = oldest entry; undefined when empty
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  AW+1  current fill level, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Pointers wr_ptr, rd_ptr are AW+1 bits. The low AW bits address the storage. empty = pointers equal. full = low bits equal and MSBs differ.
- rd_acc = rd && !empty. A read while empty is rejected and sets underflow. There is no pass-through of a same-cycle write.
- wr_acc = wr && (!full || rd_acc). When full and a read is accepted in the same cycle, the write is also accepted. A write while full without a read is rejected and sets overflow.
- On wr_acc: mem[wr_ptr[AW-1:0]] <= din; wr_ptr increments.
- On rd_acc: rd_ptr increments.
- Pointer wrap-around is natural modulo 2^(AW+1).
- count update:
  - +1 on write only
  - −1 on read only
  - unchanged when both or neither are accepted
- count is a register; it is not derived from pointer subtraction.
- Flags are combinational from count. almost_* thresholds are compared against the current count.
- clr has priority over wr/rd in the same cycle: the clr cycle's accesses are discarded and no error flags are set.
- reset_n low, regardless of clk:
  - pointers and count to 0
  - empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0)
  - overflow=0, underflow=0
  - storage contents are not reset.
- Reset asserted mid-burst drops all stored data. No partial state survives.

## Timing
- Write-to-dout latency: a word written at edge N is visible on dout and empty=0 after edge N (1 cycle).
- Read: dout updates to the next entry after the accepting edge. Consumers sample dout in the same cycle they assert rd.
- Flags and count reflect the post-edge state; there is no extra pipeline stage.
- Full throughput: one write and one read per cycle indefinitely, including at count=0 with write only, and at count=DEPTH with read+write.
- overflow/underflow assert the cycle after the offending edge. They hold until clr or reset.

## Structure
- Shared package fifo_pkg:
  - clog2 constant function
  - default WIDTH/DEPTH constants for the DSP chain
- Sub-module fifo_mem: simple dual-port array (one write port, clk-registered; one asynchronous read port), parameters WIDTH/DEPTH. It is kept separate so it can be swapped for block RAM later with a registered read.
- Top holds pointers, count, flags and error logic.

## Test plan
- Reset then 16 writes 0x00..0x0F (WIDTH=8, DEPTH=16) -> full=1 after the 16th edge, count=16, almost_full set at count 14. Then 16 reads -> dout sequence 0x00..0x0F, empty=1 at the end.
- Write while full without read (din=0xAA) -> rejected, overflow=1 sticky, contents unchanged. Read while empty -> underflow=1, count stays 0.
- Full FIFO, rd=wr=1 with din=0x55 -> count stays 16, dout advances. 0x55 is read out last, after the 15 remaining words.
- 40 cycles of streaming rd+wr from count=3 -> pointers wrap twice, data order intact, count stays 3.
- Empty FIFO, rd=wr=1 with din=0x77 -> write accepted, read rejected, underflow=1, count=1, dout=0x77.
- reset_n pulsed low mid-cycle during a burst at count=9 -> immediate count=0, empty=1, flags cleared. Also clr asserted with wr=1 -> count=0, no write stored.
